// File: rtl/decode_ctrl_pkg.sv
// Shared opcode encodings, control-word bit layout and issue-group helpers
// for the N-lane decode control stage.
package decode_ctrl_pkg;

    localparam int CTRL_W = 16;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_MUL  = 4'h3;
    localparam logic [3:0] OP_LD   = 4'h4;
    localparam logic [3:0] OP_ST   = 4'h5;
    localparam logic [3:0] OP_CMP  = 4'h6;
    localparam logic [3:0] OP_MOV  = 4'h7;
    localparam logic [3:0] OP_OR   = 4'h8;
    localparam logic [3:0] OP_AND  = 4'h9;
    localparam logic [3:0] OP_NOT  = 4'hA;
    localparam logic [3:0] OP_LSL  = 4'hB;
    localparam logic [3:0] OP_UBR  = 4'hC;
    localparam logic [3:0] OP_LSR  = 4'hD;
    localparam logic [3:0] OP_BEQ  = 4'hE;
    localparam logic [3:0] OP_BGT  = 4'hF;

    localparam int CTRL_ADD     = 0;
    localparam int CTRL_SUB     = 1;
    localparam int CTRL_MUL     = 2;
    localparam int CTRL_LD      = 3;
    localparam int CTRL_ST      = 4;
    localparam int CTRL_CMP     = 5;
    localparam int CTRL_MOV     = 6;
    localparam int CTRL_OR      = 7;
    localparam int CTRL_AND     = 8;
    localparam int CTRL_NOT     = 9;
    localparam int CTRL_LSL     = 10;
    localparam int CTRL_LSR     = 11;
    localparam int CTRL_BEQ     = 12;
    localparam int CTRL_BGT     = 13;
    localparam int CTRL_UBRANCH = 14;
    localparam int CTRL_WB      = 15;

    typedef enum logic {S_RUN, S_RESID} state_t;

    function automatic logic is_branch(input logic [3:0] op);
        return (op == OP_UBR) || (op == OP_BEQ) || (op == OP_BGT);
    endfunction

    function automatic logic is_mem(input logic [3:0] op);
        return (op == OP_LD) || (op == OP_ST);
    endfunction

endpackage

// File: rtl/opcode_decode.sv
// Single-lane opcode to one-hot control word decoder (purely combinational).
module opcode_decode
    import decode_ctrl_pkg::*;
#(
    parameter int OPC_W = 4
) (
    input  logic [OPC_W-1:0]  opcode_i,
    output logic [CTRL_W-1:0] ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (opcode_i)
            OP_ADD: begin ctrl_o[CTRL_ADD] = 1'b1; ctrl_o[CTRL_WB] = 1'b1; end
            OP_SUB: begin ctrl_o[CTRL_SUB] = 1'b1; ctrl_o[CTRL_WB] = 1'b1; end
            OP_MUL: begin ctrl_o[CTRL_MUL] = 1'b1; ctrl_o[CTRL_WB] = 1'b1; end
            OP_LD:  begin ctrl_o[CTRL_LD]  = 1'b1; ctrl_o[CTRL_WB] = 1'b1; end
            OP_ST:  ctrl_o[CTRL_ST]  = 1'b1;
            OP_CMP: ctrl_o[CTRL_CMP] = 1'b1;
            OP_MOV: begin ctrl_o[CTRL_MOV] = 1'b1; ctrl_o[CTRL_WB] = 1'b1; end
            OP_OR:  begin ctrl_o[CTRL_OR]  = 1'b1; ctrl_o[CTRL_WB] = 1'b1; end
            OP_AND: begin ctrl_o[CTRL_AND] = 1'b1; ctrl_o[CTRL_WB] = 1'b1; end
            OP_NOT: begin ctrl_o[CTRL_NOT] = 1'b1; ctrl_o[CTRL_WB] = 1'b1; end
            OP_LSL: begin ctrl_o[CTRL_LSL] = 1'b1; ctrl_o[CTRL_WB] = 1'b1; end
            OP_UBR: ctrl_o[CTRL_UBRANCH] = 1'b1;
            OP_LSR: begin ctrl_o[CTRL_LSR] = 1'b1; ctrl_o[CTRL_WB] = 1'b1; end
            OP_BEQ: ctrl_o[CTRL_BEQ] = 1'b1;
            OP_BGT: ctrl_o[CTRL_BGT] = 1'b1;
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/decode_ctrl_nway.sv
// N-lane decode control stage: splits bundles into issue groups (one branch,
// one memory op per group), registers one control word per lane, flushable.
module decode_ctrl_nway
    import decode_ctrl_pkg::*;
#(
    parameter int LANES = 4,
    parameter int OPC_W = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      in_valid,
    input  logic [LANES-1:0]          in_lane_en,
    input  logic [LANES*OPC_W-1:0]    in_opcode,
    output logic                      in_ready,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES-1:0]          out_lane_valid,
    output logic [LANES*CTRL_W-1:0]   out_ctrl,
    output logic                      out_split
);

    state_t                   state_q, state_d;
    logic [LANES-1:0]         resid_mask_q, resid_mask_d;
    logic [LANES*OPC_W-1:0]   resid_opc_q, resid_opc_d;
    logic                     out_valid_q, out_valid_d;
    logic [LANES-1:0]         lane_q, lane_d;
    logic [LANES*CTRL_W-1:0]  ctrl_q, ctrl_d;
    logic                     split_q, split_d;

    logic [LANES-1:0]         src_mask, grp, rest;
    logic [LANES*OPC_W-1:0]   src_opc;
    logic [LANES*CTRL_W-1:0]  dec_ctrl, grp_ctrl;
    logic                     advance, seen_br, seen_mem, cut;

    assign advance  = !out_valid_q || out_ready;
    assign in_ready = (state_q == S_RUN) && advance && !flush && !reset;

    // The residual, when present, is the only source of the next group.
    assign src_mask = (state_q == S_RESID) ? resid_mask_q : in_lane_en;
    assign src_opc  = (state_q == S_RESID) ? resid_opc_q  : in_opcode;

    always_comb begin
        grp      = '0;
        seen_br  = 1'b0;
        seen_mem = 1'b0;
        cut      = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (src_mask[i] && !cut) begin
                if (seen_br || (seen_mem && is_mem(src_opc[i*OPC_W +: OPC_W]))) begin
                    cut = 1'b1;
                end else begin
                    grp[i]   = 1'b1;
                    seen_br  = seen_br  | is_branch(src_opc[i*OPC_W +: OPC_W]);
                    seen_mem = seen_mem | is_mem(src_opc[i*OPC_W +: OPC_W]);
                end
            end
        end
    end

    assign rest = src_mask & ~grp;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        opcode_decode #(.OPC_W(OPC_W)) u_dec (
            .opcode_i (src_opc[g*OPC_W +: OPC_W]),
            .ctrl_o   (dec_ctrl[g*CTRL_W +: CTRL_W])
        );
        assign grp_ctrl[g*CTRL_W +: CTRL_W] = grp[g] ? dec_ctrl[g*CTRL_W +: CTRL_W] : '0;
    end

    always_comb begin
        state_d      = state_q;
        resid_mask_d = resid_mask_q;
        resid_opc_d  = resid_opc_q;
        out_valid_d  = out_valid_q;
        lane_d       = lane_q;
        ctrl_d       = ctrl_q;
        split_d      = split_q;
        if (flush) begin
            state_d      = S_RUN;
            resid_mask_d = '0;
            out_valid_d  = 1'b0;
            lane_d       = '0;
            ctrl_d       = '0;
            split_d      = 1'b0;
        end else if (advance) begin
            out_valid_d = 1'b0;
            lane_d      = '0;
            ctrl_d      = '0;
            split_d     = 1'b0;
            if (state_q == S_RESID) begin
                out_valid_d  = 1'b1;
                lane_d       = grp;
                ctrl_d       = grp_ctrl;
                split_d      = 1'b1;
                resid_mask_d = rest;
                if (rest == '0) state_d = S_RUN;
            end else if (in_valid && (grp != '0)) begin
                out_valid_d = 1'b1;
                lane_d      = grp;
                ctrl_d      = grp_ctrl;
                split_d     = (rest != '0);
                if (rest != '0) begin
                    resid_mask_d = rest;
                    resid_opc_d  = in_opcode;
                    state_d      = S_RESID;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_RUN;
            resid_mask_q <= '0;
            resid_opc_q  <= '0;
            out_valid_q  <= 1'b0;
            lane_q       <= '0;
            ctrl_q       <= '0;
            split_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            resid_mask_q <= resid_mask_d;
            resid_opc_q  <= resid_opc_d;
            out_valid_q  <= out_valid_d;
            lane_q       <= lane_d;
            ctrl_q       <= ctrl_d;
            split_q      <= split_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign out_lane_valid = lane_q;
    assign out_ctrl       = ctrl_q;
    assign out_split      = split_q;

endmodule

// File: tb/tb_decode_ctrl_nway.sv
// Bench for decode_ctrl_nway (LANES=4): vector table of bundles with expected
// issue groups, scoreboard queue, plus stall / flush / reset sequences.
module tb_decode_ctrl_nway;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [3:0]  in_lane_en;
    logic [15:0] in_opcode;
    logic        in_ready, out_valid, out_split;
    logic [3:0]  out_lane_valid;
    logic [63:0] out_ctrl;

    decode_ctrl_nway #(.LANES(4), .OPC_W(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_lane_en     (in_lane_en),
        .in_opcode      (in_opcode),
        .in_ready       (in_ready),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_lane_valid (out_lane_valid),
        .out_ctrl       (out_ctrl),
        .out_split      (out_split)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]       en;
        logic [15:0]      opc;
        int               ng;
        logic [3:0][3:0]  g;   // g[k] = lane mask of the k-th issue group
    } vec_t;

    typedef struct {
        logic [3:0]  lv;
        logic [63:0] ctrl;
        logic        split;
    } exp_t;

    vec_t vecs[10];
    vec_t cur;
    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    logic acc;

    function automatic logic [15:0] ref_ctrl(input logic [3:0] op);
        case (op)
            4'h1: return 16'h8001;
            4'h2: return 16'h8002;
            4'h3: return 16'h8004;
            4'h4: return 16'h8008;
            4'h5: return 16'h0010;
            4'h6: return 16'h0020;
            4'h7: return 16'h8040;
            4'h8: return 16'h8080;
            4'h9: return 16'h8100;
            4'hA: return 16'h8200;
            4'hB: return 16'h8400;
            4'hC: return 16'h4000;
            4'hD: return 16'h8800;
            4'hE: return 16'h1000;
            4'hF: return 16'h2000;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Called just after a falling edge: judges the transfer/accept that the
    // next rising edge will perform.
    task automatic settle();
        exp_t e;
        #1;
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("unexpected_group", {60'd0, out_lane_valid}, 64'd0);
            end else begin
                e = q.pop_front();
                check("grp_lane_valid", {60'd0, out_lane_valid}, {60'd0, e.lv});
                check("grp_ctrl", out_ctrl, e.ctrl);
                check("grp_split", {63'd0, out_split}, {63'd0, e.split});
            end
        end
        if (reset || flush) begin
            q.delete();
        end else if (in_valid && in_ready) begin
            acc = 1'b1;
            for (int k = 0; k < cur.ng; k++) begin
                e.lv = cur.g[k];
                e.ctrl = '0;
                for (int i = 0; i < 4; i++)
                    if (e.lv[i]) e.ctrl[i*16 +: 16] = ref_ctrl(cur.opc[i*4 +: 4]);
                e.split = (cur.ng > 1);
                q.push_back(e);
            end
        end
    endtask

    task automatic adv();
        @(negedge clk);
    endtask

    task automatic send(input int idx);
        cur = vecs[idx];
        in_lane_en = cur.en;
        in_opcode  = cur.opc;
        in_valid   = 1'b1;
        acc = 1'b0;
        for (int k = 0; k < 20 && !acc; k++) begin
            settle();
            adv();
        end
        in_valid = 1'b0;
        check("accept_timeout", {63'd0, acc}, 64'd1);
    endtask

    task automatic drain();
        for (int k = 0; k < 20; k++) begin
            if (k >= 1 && q.size() == 0) break;
            settle();
            adv();
        end
        if (q.size() != 0) begin
            check("drain_timeout", q.size(), 64'd0);
            q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{4'hF, 16'h7321, 1, 16'h000F};
        vecs[1] = '{4'hF, 16'hF2E1, 2, 16'h00C3};
        vecs[2] = '{4'hF, 16'h1454, 3, 16'h0C21};
        vecs[3] = '{4'hF, 16'h111C, 2, 16'h00E1};
        vecs[4] = '{4'hB, 16'h6050, 1, 16'h000B};
        vecs[5] = '{4'h0, 16'h1111, 0, 16'h0000};
        vecs[6] = '{4'hF, 16'hCCCC, 4, 16'h8421};
        vecs[7] = '{4'hF, 16'h5E43, 2, 16'h0087};
        vecs[8] = '{4'h9, 16'h5004, 2, 16'h0081};
        vecs[9] = '{4'h4, 16'h0F00, 1, 16'h0004};

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_lane_en = '0; in_opcode = '0; cur = vecs[0];
        adv(); adv();
        in_valid = 1'b1;
        settle();
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_lane_valid", {60'd0, out_lane_valid}, 64'd0);
        check("rst_ctrl", out_ctrl, 64'd0);
        check("rst_split", {63'd0, out_split}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd0);
        adv();
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        settle();
        check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
        adv();

        for (int v = 0; v < 10; v++) begin
            send(v);
            drain();
        end

        // Two-branch split: in_ready low while the residual is pending.
        send(1);
        settle();
        check("resid_in_ready", {63'd0, in_ready}, 64'd0);
        adv();
        settle();
        check("resid_done_in_ready", {63'd0, in_ready}, 64'd1);
        adv();
        drain();

        // Memory split with a three-cycle downstream stall on the first group.
        send(2);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            settle();
            check("stall_valid", {63'd0, out_valid}, 64'd1);
            check("stall_lane_valid", {60'd0, out_lane_valid}, 64'h1);
            check("stall_ctrl", out_ctrl, 64'h8008);
            check("stall_split", {63'd0, out_split}, 64'd1);
            check("stall_in_ready", {63'd0, in_ready}, 64'd0);
            adv();
        end
        out_ready = 1'b1;
        drain();

        // Flush in S_RESID with a new bundle offered.
        send(3);
        cur = vecs[0];
        in_lane_en = cur.en; in_opcode = cur.opc;
        flush = 1'b1; in_valid = 1'b1;
        settle();
        check("flush_in_ready", {63'd0, in_ready}, 64'd0);
        adv();
        flush = 1'b0; in_valid = 1'b0;
        settle();
        check("flush_out_valid", {63'd0, out_valid}, 64'd0);
        check("flush_lane_valid", {60'd0, out_lane_valid}, 64'd0);
        check("flush_ctrl", out_ctrl, 64'd0);
        check("flush_split", {63'd0, out_split}, 64'd0);
        check("flush_next_in_ready", {63'd1 >> 1, in_ready}, 64'd1);
        adv();
        drain();

        // Reset mid-split discards the residual.
        send(6);
        reset = 1'b1;
        settle();
        check("rst_mid_in_ready", {63'd0, in_ready}, 64'd0);
        adv();
        reset = 1'b0;
        settle();
        check("rst_mid_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_mid_lane_valid", {60'd0, out_lane_valid}, 64'd0);
        check("rst_mid_ctrl", out_ctrl, 64'd0);
        check("rst_mid_split", {63'd0, out_split}, 64'd0);
        check("rst_mid_in_ready_after", {63'd0, in_ready}, 64'd1);
        adv();
        send(0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
